// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered, handshaked ALU. Single-cycle logic/arithmetic
//                ops, iterative shift-add multiply and restoring unsigned
//                divide driven by a four-state controller. Valid/ready on
//                both the request and the result side.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_LSB = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIVD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Captured operands. For MUL, opa is the left-shifting multiplicand and
  // opb the right-shifting multiplier. For DIV, opa is the dividend that is
  // shifted out MSB-first while quotient bits shift in at the bottom, and
  // opb is the divisor. acc is the product accumulator or the remainder.
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] result;
  logic             zero_flag;

  logic             is_mul;
  logic             is_div;
  logic             last_iter;
  logic             div_by_zero;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] simple_result;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_next;

  assign is_mul      = (alu_control == OP_MUL);
  assign is_div      = (alu_control == OP_DIV);
  assign last_iter   = (count == CNT_LAST);
  assign div_by_zero = (opb == '0);
  assign shamt       = b[SHAMT_LSB +: SHAMT_W];

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  assign mul_sum = acc + (opb[0] ? opa : '0);

  // One restoring-divide step: bring down the next dividend bit and try
  // subtracting the divisor; a clear borrow bit means the divisor fits.
  assign div_shift = {acc, opa[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb};
  assign div_fits  = ~div_trial[WIDTH];
  assign quot_next = {opa[WIDTH-2:0], div_fits};
  assign rem_next  = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

  // Single-cycle operations, evaluated from the request operands at accept.
  always_comb begin
    simple_result = a + b;
    case (alu_control)
      OP_AND:  simple_result = a & b;
      OP_OR:   simple_result = a | b;
      OP_ADD:  simple_result = a + b;
      OP_SLT:  simple_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  simple_result = a ^ b;
      OP_SUB:  simple_result = a - b;
      OP_SLTU: simple_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  simple_result = a << shamt;
      OP_SRL:  simple_result = a >> shamt;
      OP_SRA:  simple_result = $unsigned($signed(a) >>> shamt);
      OP_NOR:  simple_result = ~(a | b);
      default: simple_result = a + b;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Controller next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_mul) begin
            state_next = S_MULT;
          end else if (is_div) begin
            state_next = S_DIVD;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_MULT: begin
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DIVD: begin
        if (div_by_zero || last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, iterative datapath and result/zero registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      count     <= '0;
      result    <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            acc   <= '0;
            count <= '0;
            if (!is_mul && !is_div) begin
              result    <= simple_result;
              zero_flag <= (simple_result == '0);
            end
          end
        end
        S_MULT: begin
          acc   <= mul_sum;
          opa   <= opa << 1;
          opb   <= opb >> 1;
          count <= count + 1'b1;
          if (last_iter) begin
            result    <= mul_sum;
            zero_flag <= (mul_sum == '0);
          end
        end
        S_DIVD: begin
          if (div_by_zero) begin
            // Division by zero is defined as an all-ones quotient.
            result    <= '1;
            zero_flag <= 1'b0;
          end else begin
            acc   <= rem_next;
            opa   <= quot_next;
            count <= count + 1'b1;
            if (last_iter) begin
              result    <= quot_next;
              zero_flag <= (quot_next == '0);
            end
          end
        end
        S_DONE: begin
          // zero must never be seen asserted once the result has retired.
          if (out_ready) begin
            zero_flag <= 1'b0;
          end
        end
        default: begin
          zero_flag <= 1'b0;
        end
      endcase
    end
  end

  assign alu_result = result;
  assign zero       = zero_flag;

endmodule
`default_nettype wire
